// File: rtl/msg_receiver.sv
// Framed message receiver: hunts for the 0x34 0x12 sync word, parses the 8-byte header,
// streams payload bytes into an external data RAM and holds the result until acknowledged.
module msg_receiver #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      Clock,
  input  logic                      Clear,
  input  logic [7:0]                InputByte,
  input  logic                      S2PReady,
  output logic                      RamWrite,
  output logic [RAM_ADDR_WIDTH-1:0] RamAddr,
  output logic [7:0]                RamData,
  output logic [15:0]               MsgId,
  output logic [15:0]               DataCount,
  output logic                      MsgComplete,
  input  logic                      MsgAck,
  output logic                      MsgError,
  output logic                      Overrun,
  output logic                      Busy
);

  typedef enum logic [3:0] {
    Hunt, Sync1, CountLo, CountHi, IdLo, IdHi, SeqLo, SeqHi, CheckCount, Data, Done
  } stateT;

  localparam int TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RamDepth = 32'd1 << RAM_ADDR_WIDTH;

  stateT                   stateReg, stateNext;
  logic [TimerWidth-1:0]   timerReg;
  logic [15:0]             byteCountReg;
  logic [15:0]             msgIdReg;
  logic [RAM_ADDR_WIDTH:0] byteIdxReg;

  logic        timedState, timeout, countBad, countEmpty, lastData;
  logic        ramWriteNext, msgErrorNext, overrunNext, completeNext, latchComplete;
  logic [15:0] dataLen;

  assign dataLen    = byteCountReg - 16'd8;
  assign countBad   = (byteCountReg < 16'd8) || ((32'(byteCountReg) - 32'd8) > RamDepth);
  assign countEmpty = (byteCountReg == 16'd8);
  assign lastData   = (32'(byteIdxReg) + 32'd1) == 32'(dataLen);
  assign timedState = (stateReg inside {Sync1, CountLo, CountHi, IdLo, IdHi, SeqLo, SeqHi, Data});
  // The timer is reset by a byte in the same cycle, so an arriving byte always wins over expiry.
  assign timeout    = timedState && !S2PReady && (timerReg == TimerLast);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) stateReg <= Hunt;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      Hunt:       if (S2PReady && InputByte == 8'h34) stateNext = Sync1;
      Sync1: begin
        if (S2PReady) begin
          if (InputByte == 8'h12)      stateNext = CountLo;
          else if (InputByte != 8'h34) stateNext = Hunt;
        end
      end
      CountLo:    if (S2PReady) stateNext = CountHi;
      CountHi:    if (S2PReady) stateNext = IdLo;
      IdLo:       if (S2PReady) stateNext = IdHi;
      IdHi:       if (S2PReady) stateNext = SeqLo;
      SeqLo:      if (S2PReady) stateNext = SeqHi;
      SeqHi:      if (S2PReady) stateNext = CheckCount;
      CheckCount: begin
        if (countBad)        stateNext = Hunt;
        else if (countEmpty) stateNext = Done;
        else                 stateNext = Data;
      end
      Data:       if (S2PReady && lastData) stateNext = Done;
      Done:       if (MsgAck && MsgComplete) stateNext = Hunt;
      default:    stateNext = Hunt;
    endcase
    if (timeout) stateNext = Hunt;
  end

  always_comb begin
    ramWriteNext  = (stateReg == Data) && S2PReady;
    msgErrorNext  = timeout || ((stateReg == CheckCount) && countBad);
    overrunNext   = S2PReady && ((stateReg == Done) || (stateReg == CheckCount));
    latchComplete = (stateReg == Done) && !MsgComplete;
    completeNext  = (stateReg == Done) && !(MsgComplete && MsgAck);
  end

  assign Busy = (stateReg != Hunt) && (stateReg != Done);

  // The sequence number bytes are consumed by SeqLo/SeqHi but never retained.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      timerReg     <= '0;
      byteCountReg <= '0;
      msgIdReg     <= '0;
      byteIdxReg   <= '0;
      RamWrite     <= 1'b0;
      RamAddr      <= '0;
      RamData      <= '0;
      MsgId        <= '0;
      DataCount    <= '0;
      MsgComplete  <= 1'b0;
      MsgError     <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      if (!timedState || S2PReady || timeout) timerReg <= '0;
      else                                     timerReg <= timerReg + TimerWidth'(1);

      if (S2PReady) begin
        case (stateReg)
          CountLo: byteCountReg[7:0]  <= InputByte;
          CountHi: byteCountReg[15:8] <= InputByte;
          IdLo:    msgIdReg[7:0]      <= InputByte;
          IdHi:    msgIdReg[15:8]     <= InputByte;
          default: ;
        endcase
      end

      if (stateReg == CheckCount) byteIdxReg <= '0;
      else if (ramWriteNext)      byteIdxReg <= byteIdxReg + 1'b1;

      RamWrite <= ramWriteNext;
      if (ramWriteNext) begin
        RamAddr <= byteIdxReg[RAM_ADDR_WIDTH-1:0];
        RamData <= InputByte;
      end

      MsgComplete <= completeNext;
      if (latchComplete) begin
        MsgId     <= msgIdReg;
        DataCount <= dataLen;
      end

      MsgError <= msgErrorNext;
      Overrun  <= overrunNext;
    end
  end

endmodule

// File: tb/tb_msg_receiver.sv
// Directed bench for msg_receiver: byte streams with hand-computed RAM writes,
// header fields, error/overrun pulse counts and reset behaviour.
module tb_msg_receiver;

  localparam int AW = 4;
  localparam int TO = 16;

  logic          Clock = 1'b0;
  logic          Clear = 1'b0;
  logic [7:0]    InputByte = 8'h00;
  logic          S2PReady = 1'b0;
  logic          MsgAck = 1'b0;
  logic          RamWrite, MsgComplete, MsgError, Overrun, Busy;
  logic [AW-1:0] RamAddr;
  logic [7:0]    RamData;
  logic [15:0]   MsgId, DataCount;

  int passCount = 0;
  int checkCount = 0;
  int errCount = 0;
  int ovrCount = 0;
  int wrAddr[$];
  int wrData[$];
  logic [7:0] txQ[$];

  msg_receiver #(.RAM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Clear(Clear), .InputByte(InputByte), .S2PReady(S2PReady),
    .RamWrite(RamWrite), .RamAddr(RamAddr), .RamData(RamData), .MsgId(MsgId),
    .DataCount(DataCount), .MsgComplete(MsgComplete), .MsgAck(MsgAck),
    .MsgError(MsgError), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (RamWrite) begin
      wrAddr.push_back(int'(RamAddr));
      wrData.push_back(int'(RamData));
    end
    if (MsgError) errCount++;
    if (Overrun)  ovrCount++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passCount++;
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge Clock); #1;
    InputByte = b;
    S2PReady  = 1'b1;
    @(posedge Clock); #1;
    S2PReady  = 1'b0;
  endtask

  task automatic sendQueue();
    foreach (txQ[i]) sendByte(txQ[i]);
  endtask

  task automatic waitComplete(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      if (MsgComplete) seen = 1;
    end
    checkVal(tag, {31'd0, MsgComplete}, 32'd1);
  endtask

  task automatic ackMsg();
    @(posedge Clock); #1;
    MsgAck = 1'b1;
    @(posedge Clock); #1;
    MsgAck = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    int wb, eb, ob;

    // Reset state
    #1;
    checkVal("rst_ramwrite", {31'd0, RamWrite}, 32'd0);
    checkVal("rst_complete", {31'd0, MsgComplete}, 32'd0);
    checkVal("rst_busy", {31'd0, Busy}, 32'd0);
    checkVal("rst_msgid", {16'd0, MsgId}, 32'd0);
    idle(3);
    Clear = 1'b1;
    idle(2);

    // Three-byte payload, with exact completion latency
    wb = wrAddr.size();
    txQ = '{8'h34, 8'h12, 8'h0B, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    sendQueue();
    checkVal("m1_busy", {31'd0, Busy}, 32'd1);
    sendByte(8'hCC);
    checkVal("m1_wr_strobe", {31'd0, RamWrite}, 32'd1);
    checkVal("m1_wr_addr", 32'(RamAddr), 32'd2);
    checkVal("m1_wr_data", 32'(RamData), 32'hCC);
    checkVal("m1_cmpl_n1", {31'd0, MsgComplete}, 32'd0);
    @(posedge Clock); #1;
    checkVal("m1_cmpl_n2", {31'd0, MsgComplete}, 32'd1);
    checkVal("m1_nwrites", 32'(wrAddr.size() - wb), 32'd3);
    if (wrAddr.size() - wb == 3) begin
      checkVal("m1_a0", 32'(wrAddr[wb]), 32'd0);     checkVal("m1_d0", 32'(wrData[wb]), 32'hAA);
      checkVal("m1_a1", 32'(wrAddr[wb+1]), 32'd1);   checkVal("m1_d1", 32'(wrData[wb+1]), 32'hBB);
      checkVal("m1_a2", 32'(wrAddr[wb+2]), 32'd2);   checkVal("m1_d2", 32'(wrData[wb+2]), 32'hCC);
    end
    checkVal("m1_msgid", {16'd0, MsgId}, 32'h0005);
    checkVal("m1_count", {16'd0, DataCount}, 32'd3);
    checkVal("m1_busy_done", {31'd0, Busy}, 32'd0);
    ackMsg();
    checkVal("m1_ack_clears", {31'd0, MsgComplete}, 32'd0);
    $display("msg m1 id=%04h count=%0d", MsgId, DataCount);

    // Header-only message preceded by noise and a repeated sync byte
    wb = wrAddr.size();
    txQ = '{8'h55, 8'h34, 8'h34, 8'h12, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    sendQueue();
    waitComplete("m2_complete");
    checkVal("m2_nwrites", 32'(wrAddr.size() - wb), 32'd0);
    checkVal("m2_msgid", {16'd0, MsgId}, 32'h0007);
    checkVal("m2_count", {16'd0, DataCount}, 32'd0);
    ackMsg();
    $display("msg m2 id=%04h count=%0d", MsgId, DataCount);

    // Bad byte counts: too short, and one past RAM depth (8+16+1 = 25)
    wb = wrAddr.size();
    eb = errCount;
    txQ = '{8'h34, 8'h12, 8'h05, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    sendQueue();
    idle(3);
    checkVal("short_err", 32'(errCount - eb), 32'd1);
    txQ = '{8'h34, 8'h12, 8'h19, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    sendQueue();
    idle(3);
    checkVal("long_err", 32'(errCount - eb), 32'd2);
    checkVal("bad_nwrites", 32'(wrAddr.size() - wb), 32'd0);
    checkVal("bad_busy", {31'd0, Busy}, 32'd0);
    checkVal("bad_complete", {31'd0, MsgComplete}, 32'd0);
    $display("msg bad-count errors=%0d", errCount - eb);

    // Exactly RAM depth (ByteCount 24) is accepted
    wb = wrAddr.size();
    txQ = '{8'h34, 8'h12, 8'h18, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) txQ.push_back(8'(8'h40 + i));
    sendQueue();
    waitComplete("full_complete");
    checkVal("full_nwrites", 32'(wrAddr.size() - wb), 32'd16);
    if (wrAddr.size() - wb == 16) begin
      checkVal("full_last_addr", 32'(wrAddr[wb+15]), 32'd15);
      checkVal("full_last_data", 32'(wrData[wb+15]), 32'h4F);
    end
    checkVal("full_count", {16'd0, DataCount}, 32'd16);
    checkVal("full_msgid", {16'd0, MsgId}, 32'h0033);
    ackMsg();
    $display("msg full id=%04h count=%0d", MsgId, DataCount);

    // Inter-byte timeout after 2 of 4 data bytes, then a clean message
    eb = errCount;
    txQ = '{8'h34, 8'h12, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    sendQueue();
    idle(10);
    checkVal("to_not_early", 32'(errCount - eb), 32'd0);
    idle(15);
    checkVal("to_err", 32'(errCount - eb), 32'd1);
    checkVal("to_complete", {31'd0, MsgComplete}, 32'd0);
    checkVal("to_busy", {31'd0, Busy}, 32'd0);
    wb = wrAddr.size();
    txQ = '{8'h34, 8'h12, 8'h09, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h5A};
    sendQueue();
    waitComplete("after_to_complete");
    checkVal("after_to_nwrites", 32'(wrAddr.size() - wb), 32'd1);
    if (wrAddr.size() - wb == 1) begin
      checkVal("after_to_addr", 32'(wrAddr[wb]), 32'd0);
      checkVal("after_to_data", 32'(wrData[wb]), 32'h5A);
    end
    checkVal("after_to_msgid", {16'd0, MsgId}, 32'h000A);
    checkVal("after_to_count", {16'd0, DataCount}, 32'd1);
    $display("msg timeout+recover id=%04h count=%0d", MsgId, DataCount);

    // Bytes while MsgComplete is held are dropped as overruns
    wb = wrAddr.size();
    ob = ovrCount;
    txQ = '{8'h34, 8'h12, 8'h99};
    sendQueue();
    idle(2);
    checkVal("ovr_pulses", 32'(ovrCount - ob), 32'd3);
    checkVal("ovr_nwrites", 32'(wrAddr.size() - wb), 32'd0);
    checkVal("ovr_complete", {31'd0, MsgComplete}, 32'd1);
    checkVal("ovr_msgid", {16'd0, MsgId}, 32'h000A);
    ackMsg();
    $display("msg overrun pulses=%0d", ovrCount - ob);

    // Asynchronous reset in the middle of Data
    eb = errCount;
    txQ = '{8'h34, 8'h12, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h77};
    sendQueue();
    checkVal("pre_rst_write", {31'd0, RamWrite}, 32'd1);
    Clear = 1'b0;
    #1;
    checkVal("rst_ramwrite_mid", {31'd0, RamWrite}, 32'd0);
    checkVal("rst_ramdata_mid", 32'(RamData), 32'd0);
    checkVal("rst_ramaddr_mid", 32'(RamAddr), 32'd0);
    checkVal("rst_msgid_mid", {16'd0, MsgId}, 32'd0);
    checkVal("rst_count_mid", {16'd0, DataCount}, 32'd0);
    checkVal("rst_busy_mid", {31'd0, Busy}, 32'd0);
    idle(2);
    Clear = 1'b1;
    idle(3);
    checkVal("rst_no_err", 32'(errCount - eb), 32'd0);
    txQ = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};
    sendQueue();
    waitComplete("post_rst_complete");
    checkVal("post_rst_msgid", {16'd0, MsgId}, 32'h000F);
    $display("msg post-reset id=%04h count=%0d", MsgId, DataCount);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
